acorn_init_engine: RTL

Parametrised ACORN-128 initialization engine. It latches a 128-bit key and IV on a start handshake, then clocks the 293-bit ACORN state through the full initialization sequence (ca = cb = 1) at a configurable number of state-update steps per clock. It sits between the top-level controller and the encrypt/decrypt datapath, and hands over the initialized state with a valid flag. It is the successor of the single-step, fixed-length initialization block.

---
 rtl/acorn_init_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/acorn_init_engine.sv
// ACORN-128 initialization engine: 1792-step (configurable) keyed state warm-up, STEPS_PER_CYCLE steps per clock.
// Optional macro ACORN_INIT_ZEROIZE_EN clears the key/IV shadows when a run ends.
module acorn_init_engine #(
   parameter int STEPS_PER_CYCLE = 1,
   parameter int INIT_STEPS      = 1792
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_in,
   input  logic [127:0] key_in,
   input  logic [127:0] iv_in,
   output logic         busy_out,
   output logic         done_out,
   output logic         state_valid_out,
   output logic [292:0] state_out
);

   localparam int CNT_W = $clog2(INIT_STEPS + 1);
   localparam logic [CNT_W-1:0] STEP_INC = CNT_W'(STEPS_PER_CYCLE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INIT_STEPS - STEPS_PER_CYCLE);

   typedef enum logic {IDLE, RUN} fsm_t;

   fsm_t                 fsm_q;
   fsm_t                 fsm_nx;
   logic [CNT_W-1:0]     cnt_q;
   logic [127:0]         key_sh;
   logic [127:0]         iv_sh;
   logic [292:0]         acorn_q;
   logic                 done_q;
   logic                 valid_q;
   logic                 load_en;
   logic                 run_en;
   logic                 finish;
   logic [STEPS_PER_CYCLE:0][292:0] chain;

   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic ch(input logic x, input logic y, input logic z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic msg_bit(input logic [CNT_W-1:0] i,
                                    input logic [127:0]     k,
                                    input logic [127:0]     v);
      if (i < CNT_W'(128))
         return k[i[6:0]];
      else if (i < CNT_W'(256))
         return v[i[6:0]];
      else if (i == CNT_W'(256))
         return ~k[0];
      else
         return k[i[6:0]];
   endfunction

   // One ACORN state update with ca = cb = 1; LFSR taps are folded in before ks/f read them.
   function automatic logic [292:0] acorn_step(input logic [292:0] s, input logic m);
      logic [292:0] t;
      logic         ks;
      logic         f;
      t      = s;
      t[289] = s[289] ^ s[235] ^ s[230];
      t[230] = s[230] ^ s[196] ^ s[193];
      t[193] = s[193] ^ s[160] ^ s[154];
      t[154] = s[154] ^ s[111] ^ s[107];
      t[107] = s[107] ^ s[66]  ^ s[61];
      t[61]  = s[61]  ^ s[23]  ^ s[0];
      ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
      f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ t[196] ^ ks;
      return {f ^ m, t[292:1]};
   endfunction

   assign chain[0] = acorn_q;

   for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
      assign chain[j+1] = acorn_step(chain[j], msg_bit(cnt_q + CNT_W'(j), key_sh, iv_sh));
   end

   always_comb begin
      fsm_nx  = fsm_q;
      load_en = 1'b0;
      run_en  = 1'b0;
      finish  = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (start_in) begin
               load_en = 1'b1;
               fsm_nx  = RUN;
            end
         end
         RUN: begin
            run_en = 1'b1;
            if (cnt_q == LAST_CNT) begin
               finish = 1'b1;
               fsm_nx = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         cnt_q   <= '0;
         key_sh  <= '0;
         iv_sh   <= '0;
         acorn_q <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_nx;
         done_q <= finish;
         if (load_en) begin
            key_sh  <= key_in;
            iv_sh   <= iv_in;
            acorn_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
         end
         if (run_en) begin
            acorn_q <= chain[STEPS_PER_CYCLE];
            cnt_q   <= cnt_q + STEP_INC;
         end
         if (finish) begin
            valid_q <= 1'b1;
`ifdef ACORN_INIT_ZEROIZE_EN
            key_sh  <= '0;
            iv_sh   <= '0;
`endif
         end
      end
   end

   assign busy_out        = (fsm_q == RUN);
   assign done_out        = done_q;
   assign state_valid_out = valid_q;
   assign state_out       = acorn_q;

endmodule
